// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch, waits, returns one word.
// Latency: rvalid WAIT_CYCLES+1 cycles after acceptance; one fetch per WAIT_CYCLES+2 cycles.
// Backpressure: none; busy freezes the fetch stage, and flush abandons the in-flight fetch.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic [31:0]                    addr,
  input  logic                           flush,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  output logic                           busy,
  output logic                           rvalid,
  output logic [31:0]                    rdata,
  output logic                           err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        do_read;
  logic [31:0] rd_addr;
  logic        rd_bad;

  logic [31:0] mem [DEPTH_WORDS];

  // Next-state logic; flush from any state returns to IDLE without a read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    do_read = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_d = addr;
            if (WAIT_CYCLES == 0) begin
              state_d = S_RESP;
              do_read = 1'b1;
            end else begin
              cnt_d   = 4'(WAIT_CYCLES - 1);
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = S_RESP;
            do_read = 1'b1;
          end
        end
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read path: with no wait states the read happens on the accept edge, so use the live address.
  always_comb begin
    rd_addr = (state_q == S_IDLE) ? addr : addr_q;
    rd_bad  = (rd_addr[1:0] != 2'b00) || ({2'b00, rd_addr[31:2]} >= 32'(DEPTH_WORDS));
    rdata_d = rdata_q;
    err_d   = err_q;
    if (do_read) begin
      if (rd_bad) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else begin
        rdata_d = mem[rd_addr[AW+1:2]];
        err_d   = 1'b0;
      end
    end
  end

  // Preload port; a read of the same word on this edge sees the old contents.
  always_ff @(posedge clk) begin
    if (!rst && ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes are combinational so flush and reset suppress them in the same cycle.
  always_comb begin
    busy   = ~rst & ~flush & (((state_q == S_IDLE) & req) | (state_q == S_WAIT));
    rvalid = ~rst & ~flush & (state_q == S_RESP);
    rdata  = rdata_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (3 and 0 wait states) share one stimulus stream.
// Latency: checks every cycle against a per-fetch countdown model.
// Backpressure: none; flush and reset are injected directed and at random.
module tb_imem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst, req, flush, ld_en;
  logic [31:0] addr, ld_data;
  logic [7:0]  ld_addr;
  logic        busy3, rvalid3, err3, busy0, rvalid0, err0;
  logic [31:0] rdata3, rdata0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy3), .rvalid(rvalid3), .rdata(rdata3), .err(err3)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an outstanding fetch is a countdown to its response cycle.
  logic [31:0] ref_mem [DEPTH];
  bit          m_act   [2];
  int          m_left  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_rdata [2];
  bit          m_err   [2];
  int          m_wait  [2] = '{3, 0};

  task automatic model_read(input int d, input logic [31:0] a);
    if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH)) begin
      m_rdata[d] = 32'd0;
      m_err[d]   = 1'b1;
    end else begin
      m_rdata[d] = ref_mem[a[9:2]];
      m_err[d]   = 1'b0;
    end
  endtask

  task automatic check_dut(input int d, input logic b, input logic v,
                           input logic [31:0] rd, input logic e);
    bit exp_b, exp_v;
    string p;
    p = (d == 0) ? "w3" : "w0";
    exp_b = !rst && !flush && ((!m_act[d] && req) || (m_act[d] && m_left[d] > 0));
    exp_v = !rst && !flush && m_act[d] && (m_left[d] == 0);
    chk({p, "_busy"},   32'(b),  32'(exp_b));
    chk({p, "_rvalid"}, 32'(v),  32'(exp_v));
    chk({p, "_rdata"},  rd,      m_rdata[d]);
    chk({p, "_err"},    32'(e),  32'(m_err[d]));
  endtask

  task automatic model_edge(input int d);
    if (rst) begin
      m_act[d]   = 1'b0;
      m_rdata[d] = 32'd0;
      m_err[d]   = 1'b0;
    end else if (flush) begin
      m_act[d] = 1'b0;
    end else if (m_act[d]) begin
      if (m_left[d] == 0) begin
        m_act[d] = 1'b0;
      end else begin
        m_left[d]--;
        if (m_left[d] == 0) model_read(d, m_addr[d]);
      end
    end else if (req) begin
      m_act[d]  = 1'b1;
      m_addr[d] = addr;
      m_left[d] = m_wait[d];
      if (m_left[d] == 0) model_read(d, addr);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are checked on the falling edge.
  task automatic step(input bit do_chk);
    #4;
    if (do_chk) begin
      check_dut(0, busy3, rvalid3, rdata3, err3);
      check_dut(1, busy0, rvalid0, rdata0, err0);
    end
    model_edge(0);
    model_edge(1);
    if (!rst && ld_en) ref_mem[ld_addr] = ld_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit q, input logic [31:0] a, input bit f,
                       input bit le, input logic [7:0] la, input logic [31:0] ldat);
    rst = r; req = q; addr = a; flush = f;
    ld_en = le; ld_addr = la; ld_data = ldat;
    step(1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 0, 8'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    int          sel;
    rst = 1'b1; req = 1'b0; addr = 32'h0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = 8'h0; ld_data = 32'h0;
    step(1'b0);
    drive(1, 0, 32'h0, 0, 0, 8'h0, 32'h0);

    // Preload every word so no read returns X.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 32'h0, 0, 1, 8'(i), $urandom);
    end
    drive(0, 0, 32'h0, 0, 1, 8'd2, 32'hE3A01005);
    drive(0, 0, 32'h0, 0, 1, 8'd1, 32'h11111111);

    // Basic fetch of word 2; after cycle 3 the 3-wait instance is in its response cycle.
    drive(0, 1, 32'h8, 0, 0, 8'h0, 32'h0);
    idle(3);
    chk("basic_rvalid", 32'(rvalid3), 32'd1);
    chk("basic_rdata",  rdata3,       32'hE3A01005);
    chk("basic_busy",   32'(busy3),   32'd0);
    idle(3);

    // Zero-wait stream: PC advances after each response.
    for (int i = 0; i < 6; i++) drive(0, 1, 32'(4 * (i / 2)), 0, 0, 8'h0, 32'h0);
    idle(5);

    // Flush mid-fetch, then a new fetch of word 1.
    drive(0, 1, 32'h8, 0, 0, 8'h0, 32'h0);
    idle(1);
    drive(0, 0, 32'h0, 1, 0, 8'h0, 32'h0);
    drive(0, 1, 32'h4, 0, 0, 8'h0, 32'h0);
    idle(6);

    // Flush during the response cycle.
    drive(0, 1, 32'h8, 0, 0, 8'h0, 32'h0);
    idle(3);
    drive(0, 0, 32'h0, 1, 0, 8'h0, 32'h0);
    idle(3);

    // Misaligned and out-of-range addresses.
    drive(0, 1, 32'h6, 0, 0, 8'h0, 32'h0);
    idle(5);
    drive(0, 1, 32'h400, 0, 0, 8'h0, 32'h0);
    idle(5);

    // Reset in the middle of a fetch.
    drive(0, 1, 32'h8, 0, 0, 8'h0, 32'h0);
    idle(1);
    drive(1, 0, 32'h0, 0, 0, 8'h0, 32'h0);
    idle(5);

    // Write to word 2 on the edge that reads it, then fetch it again.
    drive(0, 1, 32'h8, 0, 0, 8'h0, 32'h0);
    idle(2);
    drive(0, 0, 32'h0, 0, 1, 8'd2, 32'hCAFEF00D);
    idle(2);
    drive(0, 1, 32'h8, 0, 0, 8'h0, 32'h0);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      ra = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 1) ra = {$urandom} | 32'h400;
      else               ra = {22'h0, 8'($urandom), 2'b00};
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, ra,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            8'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Multi-cycle instruction-memory responder answering fetch requests from the instruction-fetch stage. It accepts a byte address, models a fixed number of wait states, and then returns the 32-bit instruction with a one-cycle valid pulse. While a fetch is outstanding it drives `busy`, which the fetch stage ORs into its freeze so the PC and IF/ID register hold. A side load port preloads program words for simulation and bring-up.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words stored; power of two, ≥ 2.
- `WAIT_CYCLES`, default 3: wait states between acceptance and response; range 0–15.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 1: fetch request; `addr` is valid while high.
- `addr`, input, 32: fetch byte address (the PC).
- `flush`, input, 1: abandon any in-flight fetch (branch taken).
- `ld_en`, input, 1: write enable for the preload port.
- `ld_addr`, input, log2(DEPTH_WORDS): word index to write.
- `ld_data`, input, 32: word to write.
- `busy`, output, 1: fetch accepted or pending and not yet delivered; combinational.
- `rvalid`, output, 1: one-cycle response strobe.
- `rdata`, output, 32: instruction word; registered; holds its value between responses.
- `err`, output, 1: response is an error (misaligned or out-of-range address); meaningful only with `rvalid`.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE**:
  - With `req=1` and `flush=0`: latch `addr` into `addr_q`.
  - If `WAIT_CYCLES=0`, go to RESP. Otherwise load `cnt=WAIT_CYCLES-1` and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**: while `cnt≠0`, decrement. When `cnt=0`, go to RESP.
- **Memory read**: performed on the edge that enters RESP, using `addr_q`.
  - `rdata` takes `mem[addr_q[31:2]]` and `err` takes 0.
  - If `addr_q[1:0]≠0` or `addr_q[31:2]≥DEPTH_WORDS`: `rdata` takes 0 and `err` takes 1.
- **RESP**:
  - `rvalid = ~flush`.
  - Next state is always IDLE.
  - `req` is ignored here, because the fetch stage advances the PC on this edge. There is no back-to-back acceptance.
- **busy**: `busy = (IDLE & req & ~flush) | (WAIT & ~flush)`. `busy` is 0 in RESP.
- **flush**: in any state, next state is IDLE, no response is issued for the abandoned fetch, and `rdata` is unchanged. In RESP, `flush` suppresses `rvalid` in the same cycle.
- **Load port**:
  - Synchronous write of `mem[ld_addr]` when `ld_en=1`.
  - Allowed in any state, including while `busy`.
  - A write and a read of the same word on the same edge: `rdata` gets the old contents.
- Memory contents are not reset.

## Timing
- Reset values: state=IDLE, `cnt=0`, `addr_q=0`, `rdata=0`, `err=0`, `rvalid=0`, `busy=0`.
- Reset has priority over `flush`, `req` and `ld_en`. Reset mid-fetch drops the fetch and issues no `rvalid`.
- Latency: for a request accepted in cycle k, `rvalid` is high in cycle k+1+WAIT_CYCLES.
- `busy` is high in cycles k through k+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles.
- Throughput: one fetch per WAIT_CYCLES+2 cycles, since IDLE is re-entered after every RESP.
- `rvalid` is never high for two consecutive cycles.
- `addr` is sampled only at acceptance. Later changes to `addr` during WAIT have no effect.
- `cnt` width is 4 bits and never wraps; it is compared against 0 before decrementing.

## Test plan
- **Basic fetch** (`WAIT_CYCLES=3`): preload word 2 with 0xE3A01005; `req=1`, `addr=0x8` in cycle 0.
  - Response: `busy=1` in cycles 0–3; `rvalid=1` in cycle 4 only, with `rdata=0xE3A01005` and `err=0`; `busy=0` in cycle 4.
- **Zero wait states** (`WAIT_CYCLES=0`): `req` held high with `addr` stepping 0x0, 0x4, …
  - Response: `rvalid` in cycles 1, 3, 5; `busy` in cycles 0, 2, 4; words returned in address order.
- **Flush mid-fetch**: accept at cycle 0, `flush=1` in cycle 2.
  - Response: state returns to IDLE in cycle 3; no `rvalid` through cycle 6; `rdata` keeps its previous value.
  - A new `req` to `addr=0x4` in cycle 3 → `rvalid` in cycle 7 with `mem[1]`.
- **Flush in RESP**: `flush=1` in cycle 4 of the basic scenario.
  - Response: `rvalid=0` in cycle 4; IDLE in cycle 5.
- **Errors**:
  - `addr=0x6` → `rvalid` with `err=1` and `rdata=0`.
  - `addr=0x400` with `DEPTH_WORDS=256` → `err=1` and `rdata=0`.
- **Reset and write collision**:
  - `rst=1` in cycle 2 of a fetch → no `rvalid`, outputs at reset values in cycle 3.
  - `ld_en` writing word 2 on the RESP-entry edge → `rdata` shows the old word, and the next fetch shows the new word.
